// File: rtl/img_capture_sequencer_if.sv
// Host/ImgController-facing signal bundle for img_capture_sequencer.
// slave: the sequencer. master: the host command path plus ImgController.
interface img_capture_sequencer_if #(
  parameter int PixW = 22
);
  // host request side
  logic            req_capture;
  logic            req_readout;
  logic            req_skipCount;
  logic            req_thumb;
  logic            readout_done;
  logic            busy;
  logic            done;
  logic            err;
  logic [1:0]      err_code;
  logic [1:0]      attempts;
  // ImgController side
  logic            cmd_capture;
  logic            cmd_readout;
  logic            cmd_ramBlock;
  logic            cmd_skipCount;
  logic            cmd_thumb;
  logic            status_captureDone;
  logic [PixW-1:0] status_capturePixelCount;

  modport slave (
    input  req_capture, req_readout, req_skipCount, req_thumb, readout_done,
           status_captureDone, status_capturePixelCount,
    output busy, done, err, err_code, attempts,
           cmd_capture, cmd_readout, cmd_ramBlock, cmd_skipCount, cmd_thumb
  );

  modport master (
    output req_capture, req_readout, req_skipCount, req_thumb, readout_done,
           status_captureDone, status_capturePixelCount,
    input  busy, done, err, err_code, attempts,
           cmd_capture, cmd_readout, cmd_ramBlock, cmd_skipCount, cmd_thumb
  );
endinterface

// File: rtl/img_capture_sequencer.sv
// Turns host capture/readout pulses into ImgController toggle commands,
// verifies each capture's pixel count with bounded retries, and ping-pongs
// captures between two RAM blocks so the last good image stays readable.
module img_capture_sequencer #(
  parameter int ImgWidth      = 2304,
  parameter int ImgHeight     = 1296,
  parameter int MaxRetries    = 2,
  parameter int TimeoutCycles = 108_000_000
) (
  input logic                    clk,
  input logic                    rst_,
  img_capture_sequencer_if.slave bus
);
  localparam logic [31:0] PixTotal = 32'(ImgWidth * ImgHeight);
  localparam int          TmrW     = $clog2(TimeoutCycles + 1);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TimeoutCycles - 1);

  typedef enum logic [2:0] {
    IDLE, CAP_ISSUE, CAP_WAIT, CAP_CHECK, RD_NOIMG, RD_ISSUE, RD_WAIT
  } state_t;

  state_t          r_state;
  logic            r_busy, r_done, r_err;
  logic [1:0]      r_errCode;
  logic [2:0]      r_attempts;   // one bit of headroom: MaxRetries=3 reaches 4
  logic            r_cmdCapture, r_cmdReadout, r_ramBlock, r_skip, r_thumb;
  logic            r_valid, r_validBlock, r_doneSeen;
  logic [TmrW-1:0] r_timer;

  logic w_capEvent, w_pixOk;
  assign w_capEvent = (bus.status_captureDone != r_doneSeen);
  assign w_pixOk    = (32'(bus.status_capturePixelCount) == PixTotal);

  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.err           = r_err;
  assign bus.err_code      = r_errCode;
  // attempts port is 2 bits; saturate rather than wrap if a 4th retry is configured
  assign bus.attempts      = (r_attempts > 3'd3) ? 2'd3 : r_attempts[1:0];
  assign bus.cmd_capture   = r_cmdCapture;
  assign bus.cmd_readout   = r_cmdReadout;
  assign bus.cmd_ramBlock  = r_ramBlock;
  assign bus.cmd_skipCount = r_skip;
  assign bus.cmd_thumb     = r_thumb;

  // Sequencer FSM; all outputs registered, done/err are single-cycle pulses
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state      <= IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_errCode    <= 2'd0;
      r_attempts   <= 3'd0;
      r_cmdCapture <= 1'b0;
      r_cmdReadout <= 1'b0;
      r_ramBlock   <= 1'b0;
      r_skip       <= 1'b0;
      r_thumb      <= 1'b0;
      r_valid      <= 1'b0;
      r_validBlock <= 1'b0;
      r_doneSeen   <= 1'b0;
      r_timer      <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          // capture wins; a same-cycle readout is silently dropped
          if (bus.req_capture) begin
            r_skip     <= bus.req_skipCount;
            r_ramBlock <= ~r_validBlock;
            r_attempts <= 3'd0;
            r_busy     <= 1'b1;
            r_errCode  <= 2'd0;
            r_state    <= CAP_ISSUE;
          end else if (bus.req_readout) begin
            r_busy    <= 1'b1;
            r_errCode <= 2'd0;
            if (r_valid) begin
              r_ramBlock <= r_validBlock;
              r_thumb    <= bus.req_thumb;
              r_state    <= RD_ISSUE;
            end else begin
              r_state <= RD_NOIMG;
            end
          end
        end
        CAP_ISSUE: begin
          // resync the toggle reference so only a fresh completion counts
          r_doneSeen   <= bus.status_captureDone;
          r_cmdCapture <= ~r_cmdCapture;
          r_attempts   <= r_attempts + 3'd1;
          r_timer      <= '0;
          r_state      <= CAP_WAIT;
        end
        CAP_WAIT: begin
          r_timer <= r_timer + 1'b1;
          if (w_capEvent) begin
            r_doneSeen <= bus.status_captureDone;
            r_state    <= CAP_CHECK;
          end else if (r_timer == TmrLast) begin
            r_err     <= 1'b1;
            r_errCode <= 2'd1;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end
        end
        CAP_CHECK: begin
          if (w_pixOk) begin
            r_validBlock <= r_ramBlock;
            r_valid      <= 1'b1;
            r_done       <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end else if (r_attempts <= 3'(MaxRetries)) begin
            r_state <= CAP_ISSUE;   // retry into the same block
          end else begin
            r_err     <= 1'b1;
            r_errCode <= 2'd2;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end
        end
        RD_NOIMG: begin
          r_err     <= 1'b1;
          r_errCode <= 2'd3;
          r_busy    <= 1'b0;
          r_state   <= IDLE;
        end
        RD_ISSUE: begin
          r_cmdReadout <= ~r_cmdReadout;
          r_state      <= RD_WAIT;
        end
        RD_WAIT: begin
          // no timeout here: the consumer paces the drain
          if (bus.readout_done) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_img_capture_sequencer.sv
// Directed bench for img_capture_sequencer: scoreboard of expected done/err
// pulses, a small ImgController model answering capture toggles.
module tb_img_capture_sequencer;
  localparam int W  = 2304;
  localparam int H  = 1296;
  localparam int N  = W * H;
  localparam int PW = $clog2(N + 1);
  localparam int TO = 100;
  localparam int MR = 2;

  logic clk = 1'b0;
  logic rst_;
  always #5 clk = ~clk;

  img_capture_sequencer_if #(.PixW(PW)) bus ();

  img_capture_sequencer #(
    .ImgWidth(W), .ImgHeight(H), .MaxRetries(MR), .TimeoutCycles(TO)
  ) dut (
    .clk (clk),
    .rst_(rst_),
    .bus (bus)
  );

  typedef struct { int count; int delay; } resp_t;
  typedef struct { bit is_err; logic [1:0] code; bit chk_blk; bit blk; } exp_t;

  resp_t resp_q[$];
  exp_t  sb_q[$];
  int    passes = 0;
  int    total  = 0;
  int    n_cap  = 0;
  int    n_rd   = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic push_resp(int count, int delay);
    resp_t r;
    r.count = count; r.delay = delay;
    resp_q.push_back(r);
  endtask

  task automatic sb_push(bit is_err, logic [1:0] code, bit chk_blk, bit blk);
    exp_t e;
    e.is_err = is_err; e.code = code; e.chk_blk = chk_blk; e.blk = blk;
    sb_q.push_back(e);
  endtask

  // ImgController model: after each cmd_capture toggle, answer after 'delay' negedges
  initial begin
    int    w;
    int    cnt;
    logic  prev;
    resp_t r;
    w = -1; cnt = 0; prev = 1'b0;
    bus.status_captureDone       = 1'b0;
    bus.status_capturePixelCount = '0;
    forever begin
      @(negedge clk);
      if (!rst_) begin
        prev = 1'b0;
        w    = -1;
      end else begin
        if (bus.cmd_capture !== prev) begin
          prev = bus.cmd_capture;
          if (resp_q.size() > 0) begin
            r   = resp_q.pop_front();
            w   = r.delay;
            cnt = r.count;
          end else begin
            w = -1;
          end
        end
        if (w == 0) begin
          bus.status_capturePixelCount = PW'(cnt);
          bus.status_captureDone       = ~bus.status_captureDone;
          w = -1;
        end else if (w > 0) begin
          w--;
        end
      end
    end
  end

  // Command toggle counters, sampled just after the active edge
  initial begin
    logic pc, pr;
    pc = 1'b0; pr = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_) begin
        pc = bus.cmd_capture;
        pr = bus.cmd_readout;
      end else begin
        if (bus.cmd_capture !== pc) n_cap++;
        if (bus.cmd_readout !== pr) n_rd++;
        pc = bus.cmd_capture;
        pr = bus.cmd_readout;
      end
    end
  end

  // Scoreboard: every done/err pulse must match the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done || bus.err) begin
        check("pulse_expected", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("pulse_kind", {bus.err, bus.done}, {e.is_err, ~e.is_err});
          check("pulse_code", bus.err_code, e.code);
          check("pulse_busy", bus.busy, 0);
          if (e.chk_blk) check("pulse_blk", bus.cmd_ramBlock, e.blk);
        end
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic req_cap(bit skip, bit also_rd);
    bus.req_capture   = 1'b1;
    bus.req_skipCount = skip;
    bus.req_readout   = also_rd;
    tick();
    bus.req_capture = 1'b0;
    bus.req_readout = 1'b0;
  endtask

  task automatic req_rd(bit thumb);
    bus.req_readout = 1'b1;
    bus.req_thumb   = thumb;
    tick();
    bus.req_readout = 1'b0;
  endtask

  task automatic wait_pulse(string tag);
    int n;
    n = 0;
    while (!(bus.done || bus.err) && n < 400) begin
      tick();
      n++;
    end
    check(tag, bus.done || bus.err, 1);
  endtask

  // Full capture: request, latency, block/skip, final attempts and toggle count
  task automatic do_cap(bit skip, bit blk, bit is_err, logic [1:0] code, int att);
    int c0;
    sb_push(is_err, code, 1'b1, blk);
    c0 = n_cap;
    req_cap(skip, 1'b0);
    check("cap_busy", bus.busy, 1);
    check("cap_lat_early", n_cap - c0, 0);
    check("cap_blk", bus.cmd_ramBlock, blk);
    check("cap_skip", bus.cmd_skipCount, skip);
    tick();
    check("cap_lat_2clk", n_cap - c0, 1);
    wait_pulse("cap_pulse_seen");
    check("cap_attempts", bus.attempts, att);
    check("cap_toggles", n_cap - c0, att);
    tick();
  endtask

  task automatic do_readout(bit thumb, bit blk);
    int r0;
    sb_push(1'b0, 2'd0, 1'b1, blk);
    r0 = n_rd;
    req_rd(thumb);
    check("rd_busy", bus.busy, 1);
    tick();
    check("rd_toggle", n_rd - r0, 1);
    check("rd_blk", bus.cmd_ramBlock, blk);
    check("rd_thumb", bus.cmd_thumb, thumb);
    tick(2);
    bus.readout_done = 1'b1;
    tick();
    bus.readout_done = 1'b0;
    wait_pulse("rd_pulse_seen");
    check("rd_toggle_once", n_rd - r0, 1);
    tick();
  endtask

  initial begin
    int c0, r0, n;
    rst_ = 1'b0;
    bus.req_capture = 1'b0; bus.req_readout = 1'b0;
    bus.req_skipCount = 1'b0; bus.req_thumb = 1'b0; bus.readout_done = 1'b0;
    tick(3);
    check("reset_outs", {bus.busy, bus.done, bus.err, bus.err_code, bus.attempts,
                         bus.cmd_capture, bus.cmd_readout, bus.cmd_ramBlock,
                         bus.cmd_skipCount, bus.cmd_thumb}, 0);
    rst_ = 1'b1;
    tick(2);

    // readout with no image: busy one cycle, then err code 3, no toggles
    sb_push(1'b1, 2'd3, 1'b0, 1'b0);
    req_rd(1'b1);
    check("noimg_busy", bus.busy, 1);
    check("noimg_err_early", bus.err, 0);
    tick();
    check("noimg_err", bus.err, 1);
    check("noimg_no_toggles", n_cap + n_rd, 0);
    tick();

    // good capture into block 1, readout of block 1
    push_resp(N, 3);
    do_cap(1'b1, 1'b1, 1'b0, 2'd0, 1);
    do_readout(1'b1, 1'b1);

    // ping-pong: block 0 then block 1, readout follows each
    push_resp(N, 1);
    do_cap(1'b0, 1'b0, 1'b0, 2'd0, 1);
    do_readout(1'b0, 1'b0);
    push_resp(N, 5);
    do_cap(1'b1, 1'b1, 1'b0, 2'd0, 1);
    do_readout(1'b1, 1'b1);

    // three short counts: all retries used, pixel-count error, last good block kept
    push_resp(N - 1, 2); push_resp(N - 1, 2); push_resp(N - 1, 2);
    do_cap(1'b0, 1'b0, 1'b1, 2'd2, 3);
    tick(3);
    check("err_code_held", bus.err_code, 2);
    do_readout(1'b0, 1'b1);

    // one short count then success on retry
    push_resp(N - 1, 1); push_resp(N, 1);
    do_cap(1'b0, 1'b0, 1'b0, 2'd0, 2);

    // no response: timeout on cycle 100 of the wait
    sb_push(1'b1, 2'd1, 1'b1, 1'b1);
    c0 = n_cap;
    req_cap(1'b0, 1'b0);
    tick();
    n = 0;
    while (!bus.err && n < 200) begin
      tick();
      n++;
    end
    check("timeout_cycle", n, TO);
    check("timeout_toggles", n_cap - c0, 1);
    check("timeout_attempts", bus.attempts, 1);
    tick();

    // completion on cycle 99 beats the timeout; on cycle 100 the event still wins
    push_resp(N, TO - 2);
    do_cap(1'b0, 1'b1, 1'b0, 2'd0, 1);
    push_resp(N, TO - 1);
    do_cap(1'b0, 1'b0, 1'b0, 2'd0, 1);

    // simultaneous capture+readout: capture only; readout while busy ignored
    push_resp(N, 4);
    sb_push(1'b0, 2'd0, 1'b1, 1'b1);
    c0 = n_cap; r0 = n_rd;
    req_cap(1'b1, 1'b1);
    check("both_busy", bus.busy, 1);
    tick(2);
    req_rd(1'b0);
    wait_pulse("both_pulse_seen");
    check("both_no_readout", n_rd - r0, 0);
    check("both_one_capture", n_cap - c0, 1);
    tick();

    // reset in the middle of a capture wait: everything clears, no pulse
    c0 = n_cap;
    req_cap(1'b0, 1'b0);
    tick(5);
    check("midrst_busy", bus.busy, 1);
    #2 rst_ = 1'b0;
    #1;
    check("midrst_async_outs", {bus.busy, bus.done, bus.err, bus.err_code, bus.attempts,
                                bus.cmd_capture, bus.cmd_readout, bus.cmd_ramBlock,
                                bus.cmd_skipCount, bus.cmd_thumb}, 0);
    tick(3);
    check("midrst_quiet", {bus.busy, bus.done, bus.err}, 0);
    rst_ = 1'b1;
    tick(2);
    // valid image forgotten by reset
    sb_push(1'b1, 2'd3, 1'b0, 1'b0);
    req_rd(1'b0);
    wait_pulse("postrst_pulse_seen");
    tick(2);

    check("sb_drained", sb_q.size(), 0);
    check("resp_drained", resp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
